ex_div_iter: RTL and testbench
==============================

# ex_div_iter

Parametrised iterative radix-2 restoring divider serving the EX stage's multi-cycle divide path, generalising the fixed 32-bit divider behind `div_en`/`quotient`/`remainder`/`div_complete`. It adds an operand width parameter, pipeline-flush cancellation, a divide-by-zero early-out, and an explicit result-acknowledge handshake so results are held until EX retires the instruction.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width; legal range ≥ 2.
- `ZERO_EARLY`, 1: when 1, divide-by-zero completes in one cycle; when 0, it runs the full iteration.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `div_en_i`  in  1  request; sampled only in IDLE.
- `div_sign_i`  in  1  1 = signed two's-complement operands, 0 = unsigned.
- `dividend_i`  in  WIDTH  dividend.
- `divisor_i`  in  WIDTH  divisor.
- `flush_i`  in  1  exception flush; cancels any operation.
- `res_ack_i`  in  1  EX consumes the result (EX ready-go AND MEM allowin).
- `quotient_o`  out  WIDTH  registered quotient.
- `remainder_o`  out  WIDTH  registered remainder.
- `div_complete_o`  out  1  result valid; high throughout DONE.
- `busy_o`  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC: `div_en_i`=1 and `flush_i`=0. At this edge:
  - latch |dividend| into the partial-quotient register and |divisor| into the divisor register (absolute values only when `div_sign_i`=1);
  - latch the quotient sign (operand signs differ) and the remainder sign (dividend sign);
  - clear the partial remainder (WIDTH+1 bits) and the step counter (`$clog2(WIDTH+1)` bits).
- Operands are ignored after acceptance.
- CALC step, one per cycle:
  - shift {rem, quo} left by 1;
  - trial = rem − divisor;
  - if trial ≥ 0, rem = trial and quotient LSB = 1; else quotient LSB = 0.
- After WIDTH steps → DONE. On that edge, load `quotient_o`/`remainder_o` with sign-corrected values: negate the quotient if its sign is negative, negate the remainder if the dividend was negative.
- Signed MIN / −1 yields quotient = MIN, remainder = 0. No special case; this falls out of the arithmetic.
- Divide-by-zero with `ZERO_EARLY`=1: go IDLE → DONE directly, quotient = all-ones, remainder = raw `dividend_i`. With `ZERO_EARLY`=0, the normal iteration produces the same values.
- DONE → IDLE on `res_ack_i`=1. Outputs hold their values until then. A new request is accepted only in IDLE, so ack to the next accept takes ≥ 1 cycle.
- `flush_i`=1 in any state: next state is IDLE and `div_complete_o` is low next cycle. Flush beats an ack or request in the same cycle. The result registers are not cleared.
- `rst`: state IDLE, counter 0, `quotient_o`=0, `remainder_o`=0, `div_complete_o`=0, `busy_o`=0.

## Timing
- Accept edge ends cycle T. CALC occupies T+1 … T+WIDTH. `div_complete_o`=1 from T+WIDTH+1. Latency is WIDTH+1 cycles from the request cycle (33 for WIDTH=32).
- Zero early-out: `div_complete_o`=1 at T+1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Ack in the first DONE cycle → IDLE in the next cycle. A request in that IDLE cycle is accepted.
- Reset asserted mid-CALC or mid-DONE overrides everything at that edge.

## Structure
- Shared header/package holds:
  - the state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the default `WIDTH`;
  - the divide-by-zero quotient constant.
- One sub-module, `div_step`: combinational single restoring step. It takes rem, quo-MSB and divisor, and returns the next rem and quotient bit, parametrised by WIDTH.
- Sign pre/post-processing and the FSM live in the top.

## Test plan
- Unsigned WIDTH=32, 100/7 → `div_complete_o` at T+33, quotient 14, remainder 2; `busy_o` high T+1…ack.
- Signed: −7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide-by-zero, `ZERO_EARLY`=1: 0x12345678/0 → complete at T+1, quotient 0xFFFFFFFF, remainder 0x12345678.
- Flush in the 10th CALC cycle → IDLE next cycle, `div_complete_o` never rises. A following 9/3 request → quotient 3, remainder 0 after 33 cycles.
- Hold without ack for 5 cycles while toggling `dividend_i` → outputs stable. Simultaneous ack and flush → IDLE.
- WIDTH=8 instance, unsigned 200/3 → complete at T+9, quotient 66, remainder 2. Reset mid-CALC → all outputs 0 next cycle.

Source files
------------

// File: rtl/ex_div_iter_pkg.sv
// Shared definitions for the iterative divider: state encoding, default width,
// and the divide-by-zero quotient fill bit.
package ex_div_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam int DEF_WIDTH = 32;

  // Divide-by-zero quotient is this bit replicated across the result width.
  localparam bit DIVZ_QUO_BIT = 1'b1;

endpackage

// File: rtl/ex_div_iter_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor if it fits, and report the resulting quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             quo_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             quo_bit_o
);

  logic [WIDTH:0] w_shift;
  logic           w_ge;

  assign w_shift = {rem_i[WIDTH-1:0], quo_msb_i};

  // A set rem MSB shifts out above the window, so the trial is non-negative.
  assign w_ge      = rem_i[WIDTH] | (w_shift >= {1'b0, divisor_i});
  assign rem_o     = w_ge ? (w_shift - {1'b0, divisor_i}) : w_shift;
  assign quo_bit_o = w_ge;

endmodule

// File: rtl/ex_div_iter.sv
// Iterative radix-2 restoring divider (signed/unsigned) for the EX multi-cycle path.
// Results are held in DONE until acknowledged; flush cancels from any state.
module ex_div_iter
  import ex_div_iter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit ZERO_EARLY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en_i,
  input  logic             div_sign_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  input  logic             res_ack_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_complete_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_complete;
  logic             r_busy;

  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_qbit;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_last;

  assign w_a_neg  = div_sign_i & dividend_i[WIDTH-1];
  assign w_b_neg  = div_sign_i & divisor_i[WIDTH-1];
  assign w_b_zero = (divisor_i == '0);
  assign w_a_abs  = w_a_neg ? -dividend_i : dividend_i;
  assign w_b_abs  = w_b_neg ? -divisor_i  : divisor_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (r_rem),
    .quo_msb_i (r_quo[WIDTH-1]),
    .divisor_i (r_div),
    .rem_o     (w_rem_nxt),
    .quo_bit_o (w_qbit)
  );

  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};
  assign w_quo_fix = r_qneg ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix = r_rneg ? -w_rem_nxt[WIDTH-1:0] : w_rem_nxt[WIDTH-1:0];
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_rem       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_complete  <= 1'b0;
      r_busy      <= 1'b0;
    end else if (flush_i) begin
      r_state    <= ST_IDLE;
      r_complete <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (div_en_i) begin
            r_busy <= 1'b1;
            if (ZERO_EARLY && w_b_zero) begin
              r_quotient  <= {WIDTH{DIVZ_QUO_BIT}};
              r_remainder <= dividend_i;
              r_complete  <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_quo   <= w_a_abs;
              r_div   <= w_b_abs;
              // Zero divisor keeps the all-ones quotient unnegated, matching the early-out.
              r_qneg  <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
              r_rneg  <= w_a_neg;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_quotient  <= w_quo_fix;
            r_remainder <= w_rem_fix;
            r_complete  <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ack_i) begin
            r_complete <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign quotient_o     = r_quotient;
  assign remainder_o    = r_remainder;
  assign div_complete_o = r_complete;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_ex_div_iter.sv
// Self-checking bench for ex_div_iter: a 32-bit early-out instance and an 8-bit
// full-iteration instance, checked against an arithmetic reference model.
module tb_ex_div_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en32, sg32, fl32, ack32, c32, bz32;
  logic [31:0] a32, b32, q32, r32;
  logic        en8, sg8, fl8, ack8, c8, bz8;
  logic [7:0]  a8, b8, q8, r8;

  int n_chk = 0;
  int n_bad = 0;

  ex_div_iter #(.WIDTH(32), .ZERO_EARLY(1'b1)) u_dut32 (
    .clk(clk), .rst(rst), .div_en_i(en32), .div_sign_i(sg32),
    .dividend_i(a32), .divisor_i(b32), .flush_i(fl32), .res_ack_i(ack32),
    .quotient_o(q32), .remainder_o(r32), .div_complete_o(c32), .busy_o(bz32)
  );

  ex_div_iter #(.WIDTH(8), .ZERO_EARLY(1'b0)) u_dut8 (
    .clk(clk), .rst(rst), .div_en_i(en8), .div_sign_i(sg8),
    .dividend_i(a8), .divisor_i(b8), .flush_i(fl8), .res_ack_i(ack8),
    .quotient_o(q8), .remainder_o(r8), .div_complete_o(c8), .busy_o(bz8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic en, input logic sg,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      en32 = en; sg32 = sg; a32 = a; b32 = b;
    end else begin
      en8 = en; sg8 = sg; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  task automatic set_ack(input int w, input logic v);
    if (w == 32) ack32 = v; else ack8 = v;
  endtask

  function automatic logic [31:0] get_q(input int w);
    return (w == 32) ? q32 : {24'b0, q8};
  endfunction
  function automatic logic [31:0] get_r(input int w);
    return (w == 32) ? r32 : {24'b0, r8};
  endfunction
  function automatic logic get_c(input int w);
    return (w == 32) ? c32 : c8;
  endfunction
  function automatic logic get_bz(input int w);
    return (w == 32) ? bz32 : bz8;
  endfunction

  // Reference: truncating division in 64-bit integers, then wrap to the width.
  task automatic model(input int w, input bit sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    logic [31:0] m;
    logic [7:0]  a_lo, b_lo;
    longint      sa, sb;
    m    = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    a_lo = a[7:0];
    b_lo = b[7:0];
    if ((b & m) == 0) begin
      q = m;
      r = a & m;
    end else begin
      if (sg && w == 32) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else if (sg) begin
        sa = longint'($signed(a_lo));
        sb = longint'($signed(b_lo));
      end else begin
        sa = longint'({32'b0, a & m});
        sb = longint'({32'b0, b & m});
      end
      q = 32'(sa / sb) & m;
      r = 32'(sa % sb) & m;
    end
  endtask

  task automatic do_div(input int w, input bit sg, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] eq, er, m;
    int          exp_lat, cyc;
    model(w, sg, a, b, eq, er);
    m       = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    exp_lat = (w == 32 && (b & m) == 0) ? 1 : w + 1;
    drive(w, 1'b1, sg, a, b);
    tick;
    drive(w, 1'b0, sg, ~a, ~b);
    cyc = 1;
    chk({tag, " busy"}, get_bz(w), 1);
    while (!get_c(w) && cyc < 200) begin
      tick;
      cyc++;
    end
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " quotient"}, get_q(w), eq);
    chk({tag, " remainder"}, get_r(w), er);
    set_ack(w, 1'b1);
    tick;
    set_ack(w, 1'b0);
    chk({tag, " cplt after ack"}, get_c(w), 0);
    chk({tag, " busy after ack"}, get_bz(w), 0);
  endtask

  initial begin
    logic [31:0] eq, er, a, b;
    int          cyc;
    bit          seen;

    rst = 1'b1;
    en32 = 0; sg32 = 0; a32 = 0; b32 = 0; fl32 = 0; ack32 = 0;
    en8 = 0; sg8 = 0; a8 = 0; b8 = 0; fl8 = 0; ack8 = 0;
    repeat (3) tick;
    chk("rst q32", q32, 0);
    chk("rst r32", r32, 0);
    chk("rst c32", c32, 0);
    chk("rst bz32", bz32, 0);
    chk("rst q8", q8, 0);
    chk("rst bz8", bz8, 0);
    rst = 1'b0;
    tick;

    do_div(32, 1'b0, 32'd100, 32'd7, "u 100/7");
    do_div(32, 1'b1, 32'hFFFF_FFF9, 32'd2, "s -7/2");
    do_div(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s min/-1");
    do_div(32, 1'b0, 32'h1234_5678, 32'd0, "u divz");
    do_div(32, 1'b1, 32'h8765_4321, 32'd0, "s divz");
    do_div(8, 1'b0, 32'd200, 32'd3, "w8 200/3");
    do_div(8, 1'b1, 32'h80, 32'h00, "w8 s divz");

    // Flush in the 10th CALC cycle, then a clean follow-up request.
    drive(32, 1'b1, 1'b0, 32'd1000, 32'd3);
    tick;
    drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (9) tick;
    chk("flush busy before", bz32, 1);
    fl32 = 1'b1;
    tick;
    fl32 = 1'b0;
    chk("flush busy", bz32, 0);
    chk("flush cplt", c32, 0);
    seen = 1'b0;
    repeat (40) begin
      tick;
      if (c32) seen = 1'b1;
    end
    chk("flush never cplt", seen, 0);
    do_div(32, 1'b0, 32'd9, 32'd3, "after flush 9/3");

    // Hold without ack while the dividend toggles, then ack and flush together.
    model(32, 1'b1, 32'hFFFF_FF9C, 32'd7, eq, er);
    drive(32, 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7);
    tick;
    drive(32, 1'b0, 1'b1, 32'd0, 32'd7);
    cyc = 1;
    while (!c32 && cyc < 200) begin
      tick;
      cyc++;
    end
    chk("hold latency", cyc, 33);
    for (int i = 0; i < 5; i++) begin
      a32 = $urandom;
      tick;
      chk("hold q", q32, eq);
      chk("hold r", r32, er);
      chk("hold cplt", c32, 1);
    end
    ack32 = 1'b1;
    fl32  = 1'b1;
    tick;
    ack32 = 1'b0;
    fl32  = 1'b0;
    chk("ack+flush cplt", c32, 0);
    chk("ack+flush busy", bz32, 0);

    // Reset mid-CALC on the 8-bit instance.
    drive(8, 1'b1, 1'b0, 32'd77, 32'd5);
    tick;
    drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("midrst q8", q8, 0);
    chk("midrst r8", r8, 0);
    chk("midrst c8", c8, 0);
    chk("midrst bz8", bz8, 0);
    rst = 1'b0;
    tick;
    do_div(8, 1'b0, 32'd77, 32'd5, "w8 after rst");

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      do_div(32, 1'($urandom_range(0, 1)), a, b, "rnd32");
      do_div(8, 1'($urandom_range(0, 1)), a, b, "rnd8");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
